// File: rtl/ioc_bus_pkg.sv
// Shared types and constants for the IOC-space bus fabric: FSM states,
// speed classes and the number of enable ticks each class waits for.
package ioc_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_ERR  = 2'd3
    } ioc_state_e;

    localparam logic [1:0] SPD_SLOW = 2'd0;
    localparam logic [1:0] SPD_MED  = 2'd1;
    localparam logic [1:0] SPD_FAST = 2'd2;
    localparam logic [1:0] SPD_SYNC = 2'd3;

    localparam int TICK_W = 3;

    localparam logic [31:0] IOC_DEFAULT_DAT = 32'hFFFF_FFFF;

    function automatic logic [TICK_W-1:0] spd_ticks(input logic [1:0] spd);
        case (spd)
            SPD_SLOW: return 3'd2;
            SPD_MED:  return 3'd4;
            SPD_FAST: return 3'd2;
            default:  return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/ioc_speed_timer.sv
// Counts speed-class enable ticks while the fabric waits on a fabric-acked
// slave; done_o fires in the WAIT cycle that carries the final tick.
module ioc_speed_timer
    import ioc_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_i,
    input  logic [1:0] speed_i,
    input  logic       clk2m_en_i,
    input  logic       clk8m_en_i,
    output logic       done_o
);

    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;
    logic              tick;

    always_comb begin
        tick = 1'b0;
        case (speed_i)
            SPD_SLOW:          tick = clk2m_en_i;
            SPD_MED, SPD_FAST: tick = clk8m_en_i;
            default:           tick = 1'b1;
        endcase
    end

    assign done_o = run_i && tick && (cnt_q == spd_ticks(speed_i) - TICK_W'(1));

    // Outside WAIT the count is held at zero, so enables seen in IDLE never count.
    always_comb begin
        cnt_d = '0;
        if (run_i && !done_o) begin
            cnt_d = cnt_q + TICK_W'(tick);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ioc_bus_fabric.sv
// Registered transaction engine between the CPU wishbone port and the IOC
// slaves: per-slave native or speed-timed ack, timeout error, default data.
module ioc_bus_fabric
    import ioc_bus_pkg::*;
#(
    parameter int                       N_SLAVES       = 8,
    parameter int                       DW             = 32,
    parameter logic [N_SLAVES-1:0]      SLV_NATIVE_ACK = '0,
    parameter logic [N_SLAVES*DW-1:0]   SLV_DMASK      = {N_SLAVES{{DW{1'b1}}}},
    parameter int                       TIMEOUT        = 255,
    parameter logic [DW-1:0]            DEFAULT_DAT    = DW'(IOC_DEFAULT_DAT),
    parameter int                       SW             = $clog2(N_SLAVES)
) (
    input  logic                   clkcpu,
    input  logic                   rst_n,
    input  logic                   clk2m_en,
    input  logic                   clk8m_en,
    input  logic                   m_cyc,
    input  logic                   m_stb,
    input  logic                   m_we,
    input  logic [1:0]             m_speed,
    input  logic                   m_hit,
    input  logic [SW-1:0]          m_idx,
    input  logic [DW-1:0]          m_dat_i,
    output logic [DW-1:0]          m_dat_o,
    output logic                   m_ack,
    output logic                   m_err,
    output logic [N_SLAVES-1:0]    s_cyc,
    output logic [N_SLAVES-1:0]    s_stb,
    output logic [N_SLAVES-1:0]    s_we,
    output logic [DW-1:0]          s_dat_o,
    input  logic [N_SLAVES*DW-1:0] s_dat_i,
    input  logic [N_SLAVES-1:0]    s_ack
);

    localparam int NV   = 2 ** SW;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    ioc_state_e     state_q, state_d;
    logic [SW-1:0]  idx_q, idx_d;
    logic           hit_q, hit_d;
    logic           we_q, we_d;
    logic [1:0]     spd_q, spd_d;
    logic [DW-1:0]  dat_q, dat_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic           ack_q, err_q;

    // Index-space views padded to 2**SW so out-of-range indices decode safely.
    logic [NV-1:0]  idx_ok;
    logic [NV-1:0]  native_vec;
    logic [NV-1:0]  ack_vec;
    logic [DW-1:0]  rd_vec [NV];

    for (genvar gi = 0; gi < NV; gi++) begin : g_idx
        if (gi < N_SLAVES) begin : g_on
            assign idx_ok[gi]     = 1'b1;
            assign native_vec[gi] = SLV_NATIVE_ACK[gi];
            assign ack_vec[gi]    = s_ack[gi];
            assign rd_vec[gi]     = s_dat_i[gi*DW +: DW] & SLV_DMASK[gi*DW +: DW];
        end else begin : g_off
            assign idx_ok[gi]     = 1'b0;
            assign native_vec[gi] = 1'b0;
            assign ack_vec[gi]    = 1'b0;
            assign rd_vec[gi]     = DEFAULT_DAT;
        end
    end

    logic in_wait;
    logic native;
    logic tmr_done;
    logic fin_ack;
    logic timeout;

    assign in_wait = (state_q == ST_WAIT);
    assign native  = hit_q && native_vec[idx_q];
    assign timeout = native && (to_cnt_q == TO_W'(TIMEOUT - 1));
    assign fin_ack = native ? ack_vec[idx_q] : tmr_done;

    ioc_speed_timer u_timer (
        .clk        (clkcpu),
        .rst_n      (rst_n),
        .run_i      (in_wait && !native),
        .speed_i    (spd_q),
        .clk2m_en_i (clk2m_en),
        .clk8m_en_i (clk8m_en),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hit_d    = hit_q;
        we_d     = we_q;
        spd_d    = spd_q;
        dat_d    = dat_q;
        to_cnt_d = in_wait ? to_cnt_q + TO_W'(1) : '0;
        case (state_q)
            ST_IDLE: begin
                if (m_cyc && m_stb) begin
                    idx_d   = m_idx;
                    hit_d   = m_hit && idx_ok[m_idx];
                    we_d    = m_we;
                    spd_d   = m_speed;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A master abort beats everything; an ack beats a same-cycle timeout.
                if (!m_cyc) begin
                    state_d = ST_IDLE;
                end else if (fin_ack) begin
                    dat_d   = hit_q ? rd_vec[idx_q] : DEFAULT_DAT;
                    state_d = ST_ACK;
                end else if (timeout) begin
                    dat_d   = DEFAULT_DAT;
                    state_d = ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkcpu) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            hit_q    <= 1'b0;
            we_q     <= 1'b0;
            spd_q    <= '0;
            dat_q    <= '0;
            to_cnt_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hit_q    <= hit_d;
            we_q     <= we_d;
            spd_q    <= spd_d;
            dat_q    <= dat_d;
            to_cnt_q <= to_cnt_d;
            ack_q    <= (state_d == ST_ACK);
            err_q    <= (state_d == ST_ERR);
        end
    end

    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_sel
        logic sel;
        assign sel       = in_wait && hit_q && (idx_q == SW'(gi));
        assign s_cyc[gi] = sel;
        assign s_stb[gi] = sel;
        assign s_we[gi]  = sel && we_q;
    end

    assign m_ack   = ack_q;
    assign m_err   = err_q;
    assign m_dat_o = dat_q;
    assign s_dat_o = m_dat_i;

endmodule

// File: tb/tb_ioc_bus_fabric.sv
// Scoreboard bench for ioc_bus_fabric: the driver predicts each response from
// the access rules, a negedge monitor checks strobes, timing and data.
module tb_ioc_bus_fabric;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam logic [N-1:0]    NATIVE = 8'b0010_0000;
    localparam logic [N*DW-1:0] DMASK  = {32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                          32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_FFFF, 32'hFFFF_FFFF};
    localparam int K_NONE = 0, K_ACK = 1, K_ERR = 2, K_RST = 3;

    typedef struct {
        int           kind;
        int           k;
        int           resp;
        logic [N-1:0] sel;
        bit           we;
        logic [31:0]  dat;
    } exp_t;

    logic          clkcpu = 1'b0;
    logic          rst_n = 1'b0, clk2m_en = 1'b0, clk8m_en = 1'b0;
    logic          m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0, m_hit = 1'b0;
    logic [1:0]    m_speed = '0;
    logic [2:0]    m_idx = '0;
    logic [31:0]   m_dat_i = '0;
    logic [31:0]   m_dat_o, s_dat_o;
    logic          m_ack, m_err;
    logic [N-1:0]  s_cyc, s_stb, s_we;
    logic [N-1:0]  s_ack = '0;
    logic [N*DW-1:0] s_dat_i = '0;

    exp_t        sb[$];
    int          total = 0, bad = 0, cyc = 0, ph2 = 0, ph8 = 0;
    logic [31:0] mdl_dat = '0;
    logic [31:0] sdat [N];

    ioc_bus_fabric #(
        .N_SLAVES(N), .DW(DW), .SLV_NATIVE_ACK(NATIVE), .SLV_DMASK(DMASK),
        .TIMEOUT(255), .DEFAULT_DAT(32'hFFFF_FFFF)
    ) dut (
        .clkcpu(clkcpu), .rst_n(rst_n), .clk2m_en(clk2m_en), .clk8m_en(clk8m_en),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_speed(m_speed),
        .m_hit(m_hit), .m_idx(m_idx), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
        .m_ack(m_ack), .m_err(m_err), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack)
    );

    always #5 clkcpu = ~clkcpu;
    always @(posedge clkcpu) cyc <= cyc + 1;

    function automatic bit en2(input int c);
        return (c % 16) == ph2;
    endfunction

    function automatic bit en8(input int c);
        return (c % 4) == ph8;
    endfunction

    function automatic logic [31:0] mask_of(input int i);
        case (i)
            1:       return 32'h0000_FFFF;
            2, 6:    return 32'h0000_00FF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Cycle holding m_ack for a fabric-timed access strobed in cycle k.
    function automatic int exp_fabric_resp(input int k, input int spd);
        int c = k;
        int need;
        if (spd == 3) return k + 2;
        need = (spd == 1) ? 4 : 2;
        while (need > 0) begin
            c++;
            if ((spd == 0) ? en2(c) : en8(c)) need--;
        end
        return c + 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clkcpu);
        #1;
        clk2m_en = en2(cyc);
        clk8m_en = en8(cyc);
    end

    task automatic do_txn(input bit we, input int spd, input bit hit, input int idx,
                          input int ack_dly, input int abort_a, input int rst_at,
                          input logic [31:0] seed_dat);
        exp_t e;
        int   k, full, stop, ab;
        bit   native;
        @(posedge clkcpu);
        #1;
        k = cyc;
        for (int i = 0; i < N; i++) begin
            sdat[i] = $urandom;
            if (i == idx && seed_dat != 0) sdat[i] = seed_dat;
            s_dat_i[i*DW +: DW] = sdat[i];
        end
        m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_speed = 2'(spd);
        m_hit = hit; m_idx = 3'(idx); m_dat_i = $urandom;
        native = hit && NATIVE[idx];
        e.k = k; e.we = we;
        e.sel = hit ? (N'(1) << idx) : '0;
        if (native) begin
            if (ack_dly >= 1 && ack_dly <= 255) begin full = k + ack_dly + 1; e.kind = K_ACK; end
            else begin full = k + 256; e.kind = K_ERR; end
        end else begin
            full = exp_fabric_resp(k, spd); e.kind = K_ACK;
        end
        e.dat  = (e.kind == K_ACK && hit) ? (sdat[idx] & mask_of(idx)) : 32'hFFFF_FFFF;
        e.resp = full;
        ab = 0;
        if (abort_a > 0 && !native && k + abort_a <= full - 2) begin
            ab = abort_a; e.kind = K_NONE; e.resp = k + ab + 1; e.dat = mdl_dat;
        end
        mdl_dat = e.dat;
        sb.push_back(e);
        stop = e.resp;
        while (cyc < stop) begin
            @(posedge clkcpu);
            #1;
            m_stb = 1'b0;
            s_ack = (native && ack_dly > 0 && cyc == k + ack_dly) ? e.sel : '0;
            if (ab > 0 && cyc == k + ab) m_cyc = 1'b0;
            if (rst_at > 0 && cyc == k + rst_at) begin
                rst_n = 1'b0; m_cyc = 1'b0;
                sb.delete();
                e.kind = K_RST; e.resp = cyc + 1; e.dat = '0; e.sel = '0;
                sb.push_back(e);
                mdl_dat = '0;
                stop = e.resp;
            end
        end
        m_cyc = 1'b0; s_ack = '0; rst_n = 1'b1;
    endtask

    exp_t         mon_e;
    logic [N-1:0] es, ew;
    initial forever begin
        @(negedge clkcpu);
        if (sb.size() > 0) begin
            mon_e = sb[0];
            if (!(mon_e.kind == K_RST && cyc < mon_e.resp)) begin
                es = (cyc > mon_e.k && cyc < mon_e.resp) ? mon_e.sel : '0;
                ew = mon_e.we ? es : '0;
                check("strobe", {s_cyc, s_stb, s_we}, {es, es, ew});
            end
            if (cyc == mon_e.resp) begin
                check("ack", m_ack, mon_e.kind == K_ACK);
                check("err", m_err, mon_e.kind == K_ERR);
                check("rdata", m_dat_o, mon_e.dat);
                $display("txn cyc=%0d start=%0d kind=%0d ack=%0b err=%0b dat=%08h",
                         cyc, mon_e.k, mon_e.kind, m_ack, m_err, m_dat_o);
                void'(sb.pop_front());
            end else if (m_ack || m_err) begin
                check("early_resp", {m_ack, m_err}, 2'b00);
            end
        end else if (m_ack || m_err) begin
            check("spurious_resp", {m_ack, m_err}, 2'b00);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        exp_t r;
        int   spd, idx, dly, ab;
        bit   hit;
        ph2 = $urandom_range(0, 15);
        ph8 = $urandom_range(0, 3);
        repeat (3) @(posedge clkcpu);
        #1;
        r.kind = K_RST; r.k = cyc; r.resp = cyc + 1; r.sel = '0; r.we = 1'b0; r.dat = '0;
        sb.push_back(r);
        @(posedge clkcpu);
        #1;
        rst_n = 1'b1;

        do_txn(0, 3, 1, 2, 0,   0, 0, 32'h0000_00A5);
        do_txn(0, 3, 1, 2, 0,   0, 0, 32'hDEAD_BEA5);
        do_txn(0, 0, 0, 3, 0,   0, 0, 32'h0);
        do_txn(0, 0, 1, 5, 0,   0, 0, 32'h0);
        do_txn(0, 3, 1, 5, 255, 0, 0, 32'h1357_9BDF);
        do_txn(0, 3, 1, 5, 256, 0, 0, 32'h0);
        do_txn(1, 2, 1, 1, 0,   1, 0, 32'h0);
        do_txn(0, 1, 1, 4, 0,   0, 0, 32'h0);
        do_txn(0, 2, 1, 5, 0,   0, 6, 32'h0);
        do_txn(0, 3, 1, 6, 0,   0, 0, 32'h0000_1234);

        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) @(posedge clkcpu);
            spd = $urandom_range(0, 3);
            hit = ($urandom_range(0, 3) != 0);
            idx = $urandom_range(0, N - 1);
            dly = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
            ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0;
            do_txn(1'($urandom_range(0, 1)), spd, hit, idx, dly, ab, 0, 32'h0);
        end

        repeat (4) @(posedge clkcpu);
        #1;
        check("drain", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ioc_bus_fabric.md
Name: ioc_bus_fabric

Overview:
Parametrised IOC-space bus fabric between the CPU wishbone port and N peripheral slaves (FDC, latches, podules, IOC registers, future devices). It replaces the top-level combinational select gating and priority read mux with a registered transaction engine. Per-slave native/fabric-generated acknowledge, IOC speed-class wait timing from the 2M/8M enables, a bus-timeout error, and a default read value for unmapped accesses.

Parameters:
N_SLAVES, 8, number of slave ports (2..16)
DW, 32, data width
SLV_NATIVE_ACK, {N_SLAVES{1'b0}}, bit i=1: slave i drives its own ack; 0: fabric times the ack from the speed class
SLV_DMASK, {N_SLAVES{32'hFFFF_FFFF}}, packed N_SLAVES*DW read-data mask (zero-extends 8/16-bit slaves)
TIMEOUT, 255, clkcpu cycles in WAIT before error (native-ack slaves only)
DEFAULT_DAT, 32'hFFFF_FFFF, read data for unmapped/timed-out accesses
SW, $clog2(N_SLAVES), slave index width (derived)

Ports:
clkcpu  in  1  system clock
rst_n  in  1  synchronous active-low reset
clk2m_en  in  1  2 MHz clock enable, one clkcpu cycle wide
clk8m_en  in  1  8 MHz clock enable, one clkcpu cycle wide
m_cyc  in  1  master cycle
m_stb  in  1  master strobe
m_we  in  1  master write
m_speed  in  2  IOC speed class (0 slow, 1 medium, 2 fast, 3 sync)
m_hit  in  1  decoded address maps to a slave
m_idx  in  SW  decoded slave index
m_dat_i  in  DW  master write data
m_dat_o  out  DW  registered read data
m_ack  out  1  transfer acknowledge, one-cycle pulse
m_err  out  1  timeout error, one-cycle pulse
s_cyc  out  N_SLAVES  per-slave cycle
s_stb  out  N_SLAVES  per-slave strobe
s_we  out  N_SLAVES  per-slave write, gated by select
s_dat_o  out  DW  write data to slaves (= m_dat_i)
s_dat_i  in  N_SLAVES*DW  packed slave read data, slave i at [i*DW +: DW]
s_ack  in  N_SLAVES  per-slave ack (ignored where SLV_NATIVE_ACK=0)

Behaviour:
- Reset (rst_n=0 at edge): state IDLE, m_ack=0, m_err=0, m_dat_o=0, s_cyc/s_stb/s_we=0, counters 0. Mid-transaction reset aborts silently; no ack or err is issued.
- States: IDLE, WAIT, ACK, ERR.
- IDLE: at an edge with m_cyc&m_stb, latch m_idx, m_hit, m_we and m_speed, then go to WAIT. Slave strobes are asserted from the next cycle only.
- WAIT: s_cyc/s_stb/s_we[idx] are asserted only when the latched hit=1; all other bits are 0.
  - Fabric ack (SLV_NATIVE_ACK[idx]=0, or hit=0): count ticks. speed 0: 2 clk2m_en. speed 1: 4 clk8m_en. speed 2: 2 clk8m_en. speed 3: 1 clkcpu cycle.
  - When the count is reached, capture the read data and go to ACK.
  - Native ack: when s_ack[idx]=1, capture and go to ACK.
  - Each WAIT cycle increments the timeout counter. On reaching TIMEOUT go to ERR.
  - If s_ack and timeout occur in the same cycle, the ack wins.
- Captured read data: hit ? (s_dat_i[idx] & SLV_DMASK[idx]) : DEFAULT_DAT. It is also captured on writes. m_dat_o holds its value until the next capture.
- ACK: m_ack=1 for exactly one cycle. Slave strobes drop in this cycle. Next state is IDLE unconditionally, so the master can re-strobe two cycles after the ack at the earliest.
- ERR: m_err=1 and m_ack=0 for one cycle, m_dat_o<=DEFAULT_DAT, then IDLE.
- Master abort: m_cyc=0 during WAIT returns to IDLE next cycle with no ack or err, and drops the slave strobes.
- Latency: for speed 3 with fabric ack, m_ack is high in cycle k+2, where k is the cycle in which the strobe is sampled.
- Enables are counted only in WAIT. An enable coinciding with the IDLE→WAIT edge is not counted.
- m_idx ≥ N_SLAVES is treated as hit=0.

Decomposition:
- Package ioc_bus_pkg holds: state enum (IDLE/WAIT/ACK/ERR), speed-class constants SPD_SLOW/MED/FAST/SYNC, the tick-count table (2,4,2,1), and DEFAULT_DAT.
- One sub-module, ioc_speed_timer: selects the enable by speed class, counts ticks, and flags done. It is cleared on IDLE.

Test Plan:
- Read slave 2 (fabric ack, speed 3), s_dat_i[2]=32'h0000_00A5, mask 32'h0000_00FF -> m_ack in cycle k+2, m_dat_o=32'h0000_00A5, s_stb=8'b0000_0100 for one cycle.
- Read with m_hit=0, speed 0, clk2m_en every 16 cycles -> no s_stb bit set, m_ack after the 2nd clk2m_en tick in WAIT, m_dat_o=32'hFFFF_FFFF.
- Native-ack slave 5 with no s_ack, TIMEOUT=255 -> m_err pulse after 255 WAIT cycles, m_ack stays 0, m_dat_o=32'hFFFF_FFFF.
- Native-ack slave 5 with s_ack on the exact timeout cycle -> m_ack=1, m_err=0, data is captured.
- Write to slave 1 (speed 2), then m_cyc drops after 1 cycle -> state IDLE, no ack, s_we cleared next cycle.
- rst_n=0 asserted mid-WAIT -> all outputs 0 at the next edge, then a fresh read completes normally.
